// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: byte lanes, store replication, load extraction, req/gnt/rvalid bus FSM.
// Optional WAIT-state timeout is enabled by defining LSU_TIMEOUT_EN.
module mem_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_mem_read,
    input  logic        mem_mem_write,
    input  logic [1:0]  mem_mem_size,
    input  logic        mem_mem_unsigned,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_rs2_data,
    output logic        mem_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        access_err,
    output logic        bus_timeout,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  size_q;
    logic [1:0]  offset_q;
    logic        unsigned_q;
    logic [31:0] load_data_q;

    logic        access;
    logic        req_err;
    logic        latch_req;
    logic        capture;
    logic        timeout_hit;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] shifted;
    logic [31:0] extracted;

    assign access = mem_mem_read ^ mem_mem_write;

    always_comb begin
        req_err = 1'b0;
        if (mem_mem_read && mem_mem_write) begin
            req_err = 1'b1;
        end else if (access) begin
            case (mem_mem_size)
                2'b01:   req_err = mem_alu_result[0];
                2'b10:   req_err = (mem_alu_result[1:0] != 2'b00);
                2'b11:   req_err = 1'b1;
                default: req_err = 1'b0;
            endcase
        end
    end

    // Lane selection and replication so the addressed byte lanes always carry the store data
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = mem_rs2_data;
        case (mem_mem_size)
            2'b00: begin
                be_d    = 4'b0001 << mem_alu_result[1:0];
                wdata_d = {4{mem_rs2_data[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {mem_alu_result[1], 1'b0};
                wdata_d = {2{mem_rs2_data[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = mem_rs2_data;
            end
        endcase
    end

    assign shifted = dbus_rdata >> {offset_q, 3'b000};

    always_comb begin
        extracted = shifted;
        case (size_q)
            2'b00:   extracted = {{24{~unsigned_q & shifted[7]}}, shifted[7:0]};
            2'b01:   extracted = {{16{~unsigned_q & shifted[15]}}, shifted[15:0]};
            default: extracted = shifted;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt;

    // Counts WAIT cycles; held at zero outside WAIT so every entry starts fresh
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 16'd0;
        end else if (state_q != WAIT) begin
            wait_cnt <= 16'd0;
        end else begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign timeout_hit = (state_q == WAIT) && !dbus_rvalid && (wait_cnt == TIMEOUT_LAST);
`else
    logic unused_timeout_param;

    assign unused_timeout_param = (TIMEOUT_CYCLES != 0);
    assign timeout_hit          = 1'b0;
`endif

    assign bus_timeout = timeout_hit;
    assign load_data   = load_data_q;

    always_comb begin
        state_d    = state_q;
        mem_stall  = 1'b0;
        dbus_req   = 1'b0;
        access_err = 1'b0;
        load_valid = 1'b0;
        latch_req  = 1'b0;
        capture    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_err) begin
                    access_err = 1'b1;
                end else if (access) begin
                    latch_req = 1'b1;
                    mem_stall = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                dbus_req  = 1'b1;
                mem_stall = 1'b1;
                if (dbus_gnt) begin
                    state_d = dbus_we ? DONE : WAIT;
                end
            end
            WAIT: begin
                mem_stall = 1'b1;
                if (dbus_rvalid) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                load_valid = ~dbus_we;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields are captured once in IDLE and stay frozen for the whole transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbus_addr  <= 32'd0;
            dbus_be    <= 4'd0;
            dbus_wdata <= 32'd0;
            dbus_we    <= 1'b0;
            size_q     <= 2'd0;
            offset_q   <= 2'd0;
            unsigned_q <= 1'b0;
        end else if (latch_req) begin
            dbus_addr  <= {mem_alu_result[31:2], 2'b00};
            dbus_be    <= be_d;
            dbus_wdata <= wdata_d;
            dbus_we    <= mem_mem_write;
            size_q     <= mem_mem_size;
            offset_q   <= mem_alu_result[1:0];
            unsigned_q <= mem_mem_unsigned;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_data_q <= 32'd0;
        end else if (capture) begin
            load_data_q <= extracted;
        end else if (timeout_hit) begin
            load_data_q <= 32'd0;
        end
    end

endmodule
